// File: rtl/uart_rx_irq_ctrl.sv
// uart_rx_irq_ctrl: drains the UART RX FIFO onto a valid/ready stream and raises sticky W1C interrupts.
// Defining UART_RX_OVR_EN adds the write-while-full cause (status[3]) and the saturating drop counter.
module uart_rx_irq_ctrl #(
  parameter int DEPTH = 4,
  parameter int TO_W = 16,
  localparam int CNT_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty_i,
  input  logic [CNT_W-1:0] fifo_cnt_i,
  output logic             fifo_rd_en_o,
  input  logic [7:0]       fifo_rd_data_i,
  input  logic             fifo_wr_en_i,
  input  logic             fifo_full_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic [TO_W-1:0]  timeout_i,
  input  logic [7:0]       delim_i,
  input  logic [3:0]       irq_mask_i,
  input  logic [3:0]       irq_clr_i,
  output logic             m_valid_o,
  output logic [7:0]       m_data_o,
  input  logic             m_ready_i,
  output logic [3:0]       status_o,
  output logic [7:0]       drop_cnt_o,
  output logic             irq_o
);
  typedef enum logic [1:0] {IDLE, RD, CAP, HOLD} state_e;
  state_e state_q, state_d;
  logic m_valid_q, m_valid_d, irq_q, irq_d;
  logic [7:0] m_data_q, m_data_d, drop_cnt_q, drop_cnt_d;
  logic [3:0] status_q, status_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_prev_q;
  logic hs, go, drop, thr_hit, tmo_hit, dlm_hit;

  assign hs = m_valid_q && m_ready_i;
  assign go = en_i && !fifo_empty_i;

  always_comb begin
    state_d = state_q;
    m_valid_d = m_valid_q;
    m_data_d = m_data_q;
    case (state_q)
      IDLE: state_d = go ? RD : IDLE;
      RD: state_d = CAP;
      CAP: begin
        state_d = HOLD;
        m_valid_d = 1'b1;
        m_data_d = fifo_rd_data_i;
      end
      HOLD: if (hs) begin
        m_valid_d = 1'b0;
        state_d = go ? RD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle timer restarts whenever the FIFO drains or its occupancy moves.
  assign timer_d = (fifo_empty_i || fifo_cnt_i != cnt_prev_q) ? '0 : timer_q + TO_W'(!(&timer_q));
  assign thr_hit = thresh_i != '0 && fifo_cnt_i >= thresh_i;
  assign tmo_hit = timeout_i != '0 && timer_q == timeout_i - TO_W'(1);
  assign dlm_hit = hs && m_data_q == delim_i;
  assign status_d = (status_q & ~irq_clr_i) | {drop, dlm_hit, tmo_hit, thr_hit};
  assign irq_d = |(status_q & irq_mask_i);

`ifdef UART_RX_OVR_EN
  assign drop = fifo_wr_en_i && fifo_full_i;
  assign drop_cnt_d = irq_clr_i[3] ? {7'd0, drop} : drop_cnt_q + 8'(drop && !(&drop_cnt_q));
`else
  logic unused_ovr;
  assign unused_ovr = fifo_wr_en_i ^ fifo_full_i;
  assign drop = 1'b0;
  assign drop_cnt_d = 8'd0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_valid_q <= 1'b0;
      m_data_q <= 8'd0;
      status_q <= 4'd0;
      drop_cnt_q <= 8'd0;
      irq_q <= 1'b0;
      timer_q <= '0;
      cnt_prev_q <= '0;
    end else begin
      state_q <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      status_q <= status_d;
      drop_cnt_q <= drop_cnt_d;
      irq_q <= irq_d;
      timer_q <= timer_d;
      cnt_prev_q <= fifo_cnt_i;
    end
  end

  // Gated by rst_n so a reset landing in RD never pops a byte that would be lost.
  assign fifo_rd_en_o = rst_n && state_q == RD;
  assign m_valid_o = m_valid_q;
  assign m_data_o = m_data_q;
  assign status_o = status_q;
  assign drop_cnt_o = drop_cnt_q;
  assign irq_o = irq_q;
endmodule

// File: tb/tb_uart_rx_irq_ctrl.sv
// tb_uart_rx_irq_ctrl: directed and randomized checks of the RX drain/IRQ controller
// against a queue-based FIFO, byte scoreboard and rule-level status model.
module tb_uart_rx_irq_ctrl;
  localparam int DEPTH = 4, CNT_W = $clog2(DEPTH), TO_W = 16;
`ifdef UART_RX_OVR_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic fifo_empty = 1'b1, fifo_full = 1'b0, fifo_wr_en = 1'b0, fifo_rd_en;
  logic [CNT_W-1:0] fifo_cnt = '0, thresh = '0;
  logic [TO_W-1:0] timeout = '0;
  logic [7:0] fifo_rd_data = 8'd0, wr_byte = 8'd0, delim = 8'h23, m_data, drop_cnt;
  logic [3:0] irq_mask = 4'd0, irq_clr = 4'd0, status;
  logic en = 1'b0, m_ready = 1'b0, m_valid, irq;
  int checks = 0, errors = 0;
  logic [7:0] fq[$], sb[$];
  logic [3:0] exp_status = 4'd0;
  logic exp_irq = 1'b0;
  logic [7:0] exp_drop = 8'd0;
  int quiet = 0;
  logic [CNT_W-1:0] prev_cnt = '0;

  always #5 clk = ~clk;

  uart_rx_irq_ctrl #(.DEPTH(DEPTH), .TO_W(TO_W)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty_i(fifo_empty), .fifo_cnt_i(fifo_cnt),
    .fifo_rd_en_o(fifo_rd_en), .fifo_rd_data_i(fifo_rd_data), .fifo_wr_en_i(fifo_wr_en),
    .fifo_full_i(fifo_full), .en_i(en), .thresh_i(thresh), .timeout_i(timeout), .delim_i(delim),
    .irq_mask_i(irq_mask), .irq_clr_i(irq_clr), .m_valid_o(m_valid), .m_data_o(m_data),
    .m_ready_i(m_ready), .status_o(status), .drop_cnt_o(drop_cnt), .irq_o(irq)
  );

  // FIFO with DEPTH-1 usable entries plus the expected byte stream and interrupt status.
  always @(posedge clk) begin
    logic hs, drop_ev;
    logic [7:0] hd;
    logic [3:0] set;
    hs = m_valid === 1'b1 && m_ready;
    hd = sb.size() > 0 ? sb[0] : 8'h00;
    drop_ev = fifo_wr_en && fifo_full;
    if (fifo_rd_en === 1'b1 && fq.size() > 0) fifo_rd_data <= fq.pop_front();
    if (fifo_wr_en && !fifo_full) begin
      fq.push_back(wr_byte);
      sb.push_back(wr_byte);
    end
    fifo_cnt <= CNT_W'(fq.size());
    fifo_empty <= fq.size() == 0;
    fifo_full <= fq.size() == DEPTH - 1;
    if (!rst_n) begin
      sb = fq;
      exp_status <= 4'd0;
      exp_irq <= 1'b0;
      exp_drop <= 8'd0;
      quiet <= 0;
      prev_cnt <= '0;
    end else begin
      if (hs && sb.size() > 0) void'(sb.pop_front());
      set[0] = thresh != 0 && fifo_cnt >= thresh;
      set[1] = timeout != 0 && quiet == int'(timeout) - 1;
      set[2] = hs && hd == delim;
      set[3] = OVR && drop_ev;
      exp_status <= (exp_status & ~irq_clr) | set;
      exp_irq <= |(exp_status & irq_mask);
      if (OVR && irq_clr[3]) exp_drop <= drop_ev ? 8'd1 : 8'd0;
      else if (set[3] && exp_drop != 8'hFF) exp_drop <= exp_drop + 8'd1;
      quiet <= (!fifo_empty && fifo_cnt == prev_cnt) ? quiet + 1 : 0;
      prev_cnt <= fifo_cnt;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_wr_en = 1'b1;
    wr_byte = b;
    @(negedge clk);
    fifo_wr_en = 1'b0;
  endtask

  task automatic drain_reset();
    en = 1'b1; m_ready = 1'b1; fifo_wr_en = 1'b0; irq_clr = 4'd0;
    repeat (20) @(negedge clk);
    en = 1'b0; m_ready = 1'b0; rst_n = 1'b0;
    thresh = '0; timeout = '0; irq_mask = 4'd0; delim = 8'h23;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({m_valid, m_data, status, drop_cnt, irq, fifo_rd_en} !== 23'd0) begin
      errors++;
      $display("FAIL reset_state got valid %b data %h status %b drop %0d irq %b rd %b want all 0", m_valid, m_data, status, drop_cnt, irq, fifo_rd_en);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [1:10] rd_x = 10'b1001000000, v_x = 10'b0010010000;
    m_ready = 1'b1;
    push(8'h41); push(8'h42);
    repeat (2) @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== rd_x[k] || m_valid !== v_x[k]) begin
        errors++;
        $display("FAIL basic_timing cyc %0d got rd %b valid %b want rd %b valid %b", k, fifo_rd_en, m_valid, rd_x[k], v_x[k]);
      end
      if (v_x[k]) begin
        checks++;
        if (m_data !== (k == 3 ? 8'h41 : 8'h42)) begin
          errors++;
          $display("FAIL basic_data cyc %0d got %h want %h", k, m_data, k == 3 ? 8'h41 : 8'h42);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int pops = 0;
    logic [7:0] got[$];
    en = 1'b0; m_ready = 1'b0;
    push(8'h51); push(8'h52); push(8'h53);
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) pops++;
      if (k >= 3) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h51) begin
          errors++;
          $display("FAIL bp_hold cyc %0d got valid %b data %h want 1 51", k, m_valid, m_data);
        end
      end
    end
    checks++;
    if (pops != 1) begin
      errors++;
      $display("FAIL bp_pops got %0d want 1", pops);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (m_valid === 1'b1) got.push_back(m_data);
      @(negedge clk);
    end
    checks++;
    if (got.size() != 3 || got[0] !== 8'h51 || got[1] !== 8'h52 || got[2] !== 8'h53) begin
      errors++;
      $display("FAIL bp_order got %0d bytes %p want 51 52 53", got.size(), got);
    end
  endtask

  task automatic test_threshold();
    drain_reset();
    thresh = 2; irq_mask = 4'b0001;
    push(8'h01); push(8'h02);
    checks++;
    if (status[0] !== 1'b0) begin errors++; $display("FAIL thr_early got %b want 0", status[0]); end
    @(negedge clk);
    checks++;
    if (status[0] !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL thr_set got st %b irq %b want 1 0", status[0], irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL thr_irq got %b want 1", irq); end
    irq_clr = 4'b0001;
    @(negedge clk);
    irq_clr = 4'b0000;
    checks++;
    if (status[0] !== 1'b1) begin errors++; $display("FAIL thr_set_wins got %b want 1", status[0]); end
    en = 1'b1; m_ready = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (fifo_empty !== 1'b1 || status[0] !== 1'b1) begin errors++; $display("FAIL thr_sticky got empty %b st %b want 1 1", fifo_empty, status[0]); end
    irq_clr = 4'b0001;
    @(negedge clk);
    irq_clr = 4'b0000;
    checks++;
    if (status[0] !== 1'b0) begin errors++; $display("FAIL thr_clear got %b want 0", status[0]); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL thr_irq_off got %b want 0", irq); end
  endtask

  task automatic test_timeout();
    drain_reset();
    timeout = 5; irq_mask = 4'b0010;
    push(8'h10);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (status[1] !== (k >= 6)) begin errors++; $display("FAIL tmo_fire cyc %0d got %b want %b", k, status[1], k >= 6); end
    end
    irq_clr = 4'b0010;
    @(negedge clk);
    irq_clr = 4'b0000;
    repeat (10) @(negedge clk);
    checks++;
    if (status[1] !== 1'b0) begin errors++; $display("FAIL tmo_once got %b want 0", status[1]); end
    drain_reset();
    timeout = 5;
    push(8'h11);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      fifo_wr_en = 1'b0;
      checks++;
      if (status[1] !== (k >= 10)) begin errors++; $display("FAIL tmo_restart cyc %0d got %b want %b", k, status[1], k >= 10); end
      if (k == 3) begin fifo_wr_en = 1'b1; wr_byte = 8'h12; end
    end
    drain_reset();
    push(8'h13);
    repeat (20) @(negedge clk);
    checks++;
    if (status !== 4'd0) begin errors++; $display("FAIL tmo_disabled got %b want 0000", status); end
  endtask

  task automatic test_delim();
    drain_reset();
    irq_mask = 4'b0100;
    push(8'h31); push(8'h23);
    en = 1'b1;
    for (int i = 0; i < 10 && m_valid !== 1'b1; i++) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h31 || status[2] !== 1'b0) begin errors++; $display("FAIL dlm_first got v %b d %h st %b want 1 31 0", m_valid, m_data, status[2]); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (status[2] !== 1'b0) begin errors++; $display("FAIL dlm_nonmatch got %b want 0", status[2]); end
    for (int i = 0; i < 10 && m_valid !== 1'b1; i++) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h23 || status[2] !== 1'b0) begin errors++; $display("FAIL dlm_pending got v %b d %h st %b want 1 23 0", m_valid, m_data, status[2]); end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (status[2] !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL dlm_set got st %b irq %b want 1 0", status[2], irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL dlm_irq got %b want 1", irq); end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    drain_reset();
    thresh = 1; irq_mask = 4'b0001; en = 1'b1;
    push(8'h77);
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rst_rd_pre got %b want 1", fifo_rd_en); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_no_pop got %b want 0", fifo_rd_en); end
    @(negedge clk);
    checks++;
    if ({m_valid, status, irq, fifo_rd_en} !== 7'd0 || fifo_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL rst_in_rd got v %b st %b irq %b rd %b cnt %0d want 0 0 0 0 1", m_valid, status, irq, fifo_rd_en, fifo_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10 && m_valid !== 1'b1; i++) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h77) begin errors++; $display("FAIL rst_refetch got v %b d %h want 1 77", m_valid, m_data); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || status !== 4'd0) begin errors++; $display("FAIL rst_in_hold got v %b d %h st %b want 0 00 0000", m_valid, m_data, status); end
    repeat (6) begin
      @(negedge clk);
      if (m_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_discard got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_overrun();
    drain_reset();
    fifo_wr_en = 1'b1;
    for (int i = 0; i < 303; i++) begin
      wr_byte = 8'(i);
      @(negedge clk);
    end
    checks++;
    if (drop_cnt !== (OVR ? 8'd255 : 8'd0) || status[3] !== OVR) begin errors++; $display("FAIL ovr_sat got drop %0d st3 %b want %0d %b", drop_cnt, status[3], OVR ? 255 : 0, OVR); end
    irq_clr = 4'b1000;
    @(negedge clk);
    checks++;
    if (drop_cnt !== (OVR ? 8'd1 : 8'd0)) begin errors++; $display("FAIL ovr_clr_drop got %0d want %0d", drop_cnt, OVR ? 1 : 0); end
    fifo_wr_en = 1'b0;
    @(negedge clk);
    irq_clr = 4'b0000;
    checks++;
    if (drop_cnt !== 8'd0 || status[3] !== 1'b0) begin errors++; $display("FAIL ovr_clear got drop %0d st3 %b want 0 0", drop_cnt, status[3]); end
  endtask

  task automatic test_random();
    logic stall = 1'b0;
    logic [7:0] held = 8'd0;
    drain_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if ({status, irq, drop_cnt} !== {exp_status, exp_irq, exp_drop}) begin
        errors++;
        $display("FAIL rnd_status cyc %0d got st %b irq %b drop %0d want st %b irq %b drop %0d", i, status, irq, drop_cnt, exp_status, exp_irq, exp_drop);
      end
      if (stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== held) begin errors++; $display("FAIL rnd_stable cyc %0d got v %b d %h want 1 %h", i, m_valid, m_data, held); end
      end
      en = $urandom_range(0, 3) != 0;
      m_ready = $urandom_range(0, 2) != 0;
      fifo_wr_en = $urandom_range(0, 9) < 4;
      wr_byte = $urandom_range(0, 3) == 0 ? 8'h23 : 8'($urandom);
      irq_clr = $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 63) == 0) begin
        thresh = CNT_W'($urandom);
        timeout = TO_W'($urandom_range(0, 7));
        irq_mask = 4'($urandom);
      end
      if (m_valid === 1'b1 && m_ready) begin
        checks++;
        if (sb.size() == 0 || m_data !== sb[0]) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h (sb size %0d)", i, m_data, sb.size() > 0 ? sb[0] : 8'h00, sb.size()); end
      end
      stall = m_valid === 1'b1 && !m_ready;
      held = m_data;
    end
    fifo_wr_en = 1'b0; irq_clr = 4'd0; en = 1'b1; m_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (sb.size() != 0 || m_valid !== 1'b0 || fifo_empty !== 1'b1) begin errors++; $display("FAIL rnd_drain got sb %0d valid %b empty %b want 0 0 1", sb.size(), m_valid, fifo_empty); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_threshold();
    test_timeout();
    test_delim();
    test_reset_mid();
    test_overrun();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
